// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver, mid-bit sampling, LSB first, one stop bit.
// Emits a one-clock rx_valid per good frame and one frame_err per bad stop bit.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 os_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 rx_busy
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS) + 1;
    localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t               state_q;
    logic [1:0]           sync_q;
    logic [TW-1:0]        tick_q;
    logic [BW-1:0]        idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 ferr_q;
    logic                 busy_q;
    logic                 rx_s;

    assign rx_s      = sync_q[1];
    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign rx_busy   = busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sync_q  <= 2'b11;
            tick_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx};
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            if (os_tick) begin
                case (state_q)
                    IDLE: if (!rx_s) begin
                        state_q <= START;
                        tick_q  <= '0;
                        busy_q  <= 1'b1;
                    end
                    START: if (tick_q == HALF) begin
                        tick_q <= '0;
                        idx_q  <= '0;
                        // a line that is high again at mid start bit was only a glitch
                        state_q <= rx_s ? IDLE : DATA;
                        busy_q  <= !rx_s;
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                    DATA: if (tick_q == FULL) begin
                        shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                        tick_q  <= '0;
                        if (idx_q == LAST) state_q <= STOP;
                        else idx_q <= idx_q + 1'b1;
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                    STOP: if (tick_q == FULL) begin
                        tick_q <= '0;
                        if (rx_s) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= BRK;
                        end
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                    BRK: if (rx_s) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven frames plus glitch, break and mid-frame reset sequences.
module tb_uart_rx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       os_tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;

    int n_chk = 0;
    int n_fail = 0;
    int n_valid = 0;
    int n_ferr = 0;
    int tcnt = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        int         period;
        logic       stop;
        int         gap;
    } vec_t;
    vec_t vt[5];

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .clk(clk), .rst(rst), .os_tick(os_tick), .rx(rx),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        tcnt = (tcnt + 1) % 4;
        os_tick = (tcnt == 0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                n_valid++;
                check("valid_excl_ferr", {31'd0, frame_err}, 32'd0);
                if (exp_q.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
                else check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
            end
            if (frame_err) n_ferr++;
        end
    end

    task automatic send(input logic [7:0] d, input int per, input logic stop);
        rx = 1'b0;
        repeat (per) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            if (i == 3) begin
                repeat (per / 2) @(negedge clk);
                check("busy_mid", {31'd0, rx_busy}, 32'd1);
                repeat (per - per / 2) @(negedge clk);
            end else begin
                repeat (per) @(negedge clk);
            end
        end
        rx = stop;
        repeat (per) @(negedge clk);
        if (stop) check("busy_end", {31'd0, rx_busy}, 32'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int v0, f0;
        logic [7:0] prev;
        logic [7:0] b;
        vt[0] = '{8'h55, 64, 1'b1, 128};
        vt[1] = '{8'hA3, 64, 1'b1, 0};
        vt[2] = '{8'h0F, 64, 1'b1, 128};
        vt[3] = '{8'hC9, 66, 1'b1, 128};
        vt[4] = '{8'hC9, 62, 1'b1, 128};

        repeat (3) @(negedge clk);
        check("rst_data", {24'd0, rx_data}, 32'd0);
        check("rst_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        check("rst_busy", {31'd0, rx_busy}, 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        for (int k = 0; k < 5; k++) begin
            if (vt[k].stop) exp_q.push_back(vt[k].data);
            send(vt[k].data, vt[k].period, vt[k].stop);
            repeat (vt[k].gap) @(negedge clk);
        end
        drain();
        check("table_valid_count", n_valid, 32'd5);
        check("table_ferr_count", n_ferr, 32'd0);

        // glitch of three os_ticks
        v0 = n_valid; f0 = n_ferr; prev = rx_data;
        rx = 1'b0;
        repeat (12) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch_busy", {31'd0, rx_busy}, 32'd0);
        check("glitch_valid", n_valid - v0, 32'd0);
        check("glitch_ferr", n_ferr - f0, 32'd0);
        check("glitch_data", {24'd0, rx_data}, {24'd0, prev});

        // bad stop bit followed by a long break
        v0 = n_valid; f0 = n_ferr; prev = rx_data;
        send(8'h3C, 64, 1'b0);
        repeat (20 * 64) @(negedge clk);
        check("break_busy", {31'd0, rx_busy}, 32'd1);
        rx = 1'b1;
        repeat (128) @(negedge clk);
        check("break_ferr", n_ferr - f0, 32'd1);
        check("break_valid", n_valid - v0, 32'd0);
        check("break_data", {24'd0, rx_data}, {24'd0, prev});
        check("break_idle", {31'd0, rx_busy}, 32'd0);
        exp_q.push_back(8'h81);
        send(8'h81, 64, 1'b1);
        repeat (64) @(negedge clk);
        drain();
        check("after_break_data", {24'd0, rx_data}, 32'h81);

        // reset in the middle of data bit 4
        v0 = n_valid; f0 = n_ferr;
        b = 8'h55;
        rx = 1'b0;
        repeat (64) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            repeat (64) @(negedge clk);
        end
        rx = b[4];
        repeat (32) @(negedge clk);
        check("pre_rst_busy", {31'd0, rx_busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_data", {24'd0, rx_data}, 32'd0);
        check("async_rst_busy", {31'd0, rx_busy}, 32'd0);
        check("async_rst_valid", {31'd0, rx_valid}, 32'd0);
        check("async_rst_ferr", {31'd0, frame_err}, 32'd0);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (128) @(negedge clk);
        exp_q.push_back(8'h7E);
        send(8'h7E, 64, 1'b1);
        repeat (64) @(negedge clk);
        drain();
        check("rst_abort_valid", n_valid - v0, 32'd1);
        check("rst_abort_ferr", n_ferr - f0, 32'd0);
        check("after_rst_data", {24'd0, rx_data}, 32'h7E);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver, the receive-side counterpart of the team's 1x-baud uart_tx, and used on the same serial link. It oversamples the asynchronous rx line on a shared OVERSAMPLE x baud tick, validates the start bit at mid-bit, and assembles DATA_BITS data bits LSB first. It checks the stop bit and presents each byte with a one-cycle valid strobe, or reports a framing error. It sits between the pad/loopback line and the consumer logic (FIFO or command decoder).

Parameters:
DATA_BITS, 8, data bits per frame; no parity; 1 stop bit.
OVERSAMPLE, 16, os_tick pulses per bit period; even, >= 4.

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous, active-high
os_tick  input  1  single-cycle enable pulse at OVERSAMPLE x baud
rx  input  1  serial line, asynchronous to clk; idle = 1
rx_data  output  DATA_BITS  last correctly framed byte; holds until the next good frame
rx_valid  output  1  1-clk pulse; rx_data is new this cycle
frame_err  output  1  1-clk pulse; stop bit sampled 0
rx_busy  output  1  1 while state != IDLE

Behaviour:
- Reset (async assert, clocked-domain deassert):
  - state=IDLE, rx_data=0, rx_valid=0, frame_err=0, rx_busy=0.
  - Synchronizer flops = 1; tick_cnt=0; bit_index=0; shifter=0.
- Reset mid-frame aborts the frame. No rx_valid or frame_err is produced for the aborted frame.
- rx passes through a 2-flop synchronizer (reset to 1). rx_s is the second flop's output. All decisions use rx_s.
- Counters:
  - tick_cnt is $clog2(OVERSAMPLE) bits wide and advances only on os_tick.
  - bit_index is $clog2(DATA_BITS)+1 bits wide.
- All state and counter updates are qualified by os_tick. rx_valid and frame_err are cleared to 0 on every clk where they are not being set.
- IDLE:
  - On os_tick with rx_s=0: go to START, tick_cnt=0.
- START:
  - On os_tick, tick_cnt++.
  - When tick_cnt==OVERSAMPLE/2-1 (mid start bit):
    - rx_s=0: go to DATA, tick_cnt=0, bit_index=0.
    - rx_s=1: glitch; go back to IDLE. No flag is raised.
- DATA:
  - On os_tick, tick_cnt++.
  - When tick_cnt==OVERSAMPLE-1 (mid data bit): shifter={rx_s, shifter[DATA_BITS-1:1]} (LSB first), tick_cnt=0.
  - If bit_index==DATA_BITS-1, go to STOP; otherwise bit_index++.
- STOP:
  - When tick_cnt==OVERSAMPLE-1 (mid stop bit), tick_cnt=0, then:
    - rx_s=1: rx_data<=shifter, rx_valid=1 for exactly one clk, go to IDLE.
    - rx_s=0: frame_err=1 for one clk, rx_data unchanged, go to BREAK.
- BREAK:
  - Remains here until an os_tick with rx_s=1, then goes to IDLE.
  - A held-low line (break) therefore produces exactly one frame_err, not a stream of them.
- Returning to IDLE at mid stop bit lets back-to-back frames be received. The next falling edge can arrive anywhere in the second half of the stop bit.
- rx_busy is registered and equals (state != IDLE). It is set on the same os_tick that leaves IDLE.
- Latency: rx_valid asserts on the os_tick at the middle of the stop bit, i.e. ~(DATA_BITS+1.5) bit periods after the falling edge, plus 2 clk for the synchronizer.
- rx_valid and frame_err are never asserted together. No backpressure: an unconsumed rx_data is simply overwritten by the next good frame.
- Tolerance: correct reception with up to ±3% baud mismatch at the default parameters.

Test Plan:
- 0x55 received at os_tick every 4 clk (bit = 64 clk), ideal timing -> one rx_valid, rx_data=0x55, frame_err never 1, rx_busy high from start detection to mid stop.
- Back-to-back frames 0xA3 then 0x0F, with no idle gap between them -> two rx_valid pulses, data 0xA3 then 0x0F, in that order.
- Line low for 3 os_ticks then high (glitch shorter than half a bit) -> back to IDLE, no rx_valid, no frame_err, rx_data unchanged.
- Frame 0x3C with the stop bit driven 0, then line held low 20 bit periods -> exactly one frame_err, no rx_valid, rx_data keeps its previous value. After the line returns high, the next frame 0x81 is received correctly.
- Transmit 0xC9 with the bit period stretched +3% and, separately, shrunk -3% -> rx_data=0xC9 in both cases.
- Assert rst during DATA bit 4 of a frame -> all outputs 0 immediately (async), no flag for the aborted frame. A following full frame 0x7E is received after deassertion.
